// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store unit over a single-port word memory.
// Sub-word stores use read-modify-write; misaligned or out-of-range requests fault without touching memory.
module load_store_unit #(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_WE,
  output logic [31:0] mem_Address,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic        r_rsp_fault;
  logic [31:0] r_rsp_rdata;
  logic        r_mem_we;
  logic [31:0] r_mem_wd;
  logic [31:0] r_mem_addr;

  logic        w_fault;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_fault = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]))
                 | (req_addr[31:2] >= LP_WORDS);

  // Lane extraction and merge both act on the word currently presented on mem_RD.
  always_comb begin
    w_lane_byte = mem_RD[{r_lane, 3'b000} +: 8];
    w_lane_half = r_lane[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
      2'b01:   w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
      default: w_load_data = mem_RD;
    endcase
    w_merged = mem_RD;
    if (r_size == 2'b00) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_mem_we    <= 1'b0;
      r_mem_wd    <= 32'h0;
      r_mem_addr  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_lane   <= req_addr[1:0];
            r_wdata  <= req_wdata;
            if (w_fault) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_state    <= ACCESS;
              r_mem_addr <= {2'b00, req_addr[31:2]};
              if (req_we && req_size == 2'b10) begin
                r_mem_we <= 1'b1;
                r_mem_wd <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (r_we && r_size != 2'b10) begin
            r_state  <= WRITE;
            r_mem_we <= 1'b1;
            r_mem_wd <= w_merged;
          end else begin
            r_state     <= RESP;
            r_mem_we    <= 1'b0;
            r_mem_wd    <= 32'h0;
            r_mem_addr  <= 32'h0;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= r_we ? 32'h0 : w_load_data;
          end
        end
        WRITE: begin
          r_state     <= RESP;
          r_mem_we    <= 1'b0;
          r_mem_wd    <= 32'h0;
          r_mem_addr  <= 32'h0;
          r_rsp_valid <= 1'b1;
          r_rsp_fault <= 1'b0;
          r_rsp_rdata <= 32'h0;
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_fault   = r_rsp_fault;
  assign mem_WE      = r_mem_we;
  assign mem_WD      = r_mem_wd;
  assign mem_Address = r_mem_addr;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 100: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU request valid.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  load result.
REQ-013 SHALL have port rsp_fault  output  1  request rejected, qualified by rsp_valid.
REQ-014 SHALL have port mem_WE  output  1  data memory write enable.
REQ-015 SHALL have port mem_Address  output  32  word index into data memory.
REQ-016 SHALL have port mem_WD  output  32  data memory write data.
REQ-017 SHALL have port mem_RD  input  32  data memory read data, combinational from mem_Address.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, and all req_* fields are registered at that edge.
REQ-020 SHALL flag a fault at acceptance when req_size=11, or halfword with addr[0]=1, or word with addr[1:0]!=00, or addr[31:2] >= MEM_WORDS.
REQ-021 SHALL, on a faulting request, go IDLE->RESP with no memory access; in RESP: rsp_fault=1, rsp_rdata=0.
REQ-022 SHALL, on a non-faulting request, go IDLE->ACCESS, driving mem_Address = registered addr[31:2].
REQ-023 SHALL, for a load in ACCESS, capture lane-extracted mem_RD into rsp_rdata and go to RESP.
REQ-024 SHALL use little-endian lanes: byte lane addr[1:0] (lane 0 = bits 7:0), halfword lane addr[1] (0 = bits 15:0).
REQ-025 SHALL sign-extend sub-word loads when req_signed=1 and zero-extend them otherwise; word loads are returned unmodified.
REQ-026 SHALL, for a word store in ACCESS, assert mem_WE=1 with mem_WD=req_wdata for exactly that cycle, then go to RESP.
REQ-027 SHALL, for a byte or halfword store, perform read-modify-write: in ACCESS, read mem_RD and register the word with only the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0]; in WRITE, assert mem_WE=1 with the merged word; then go to RESP.
REQ-028 SHALL hold mem_Address constant from ACCESS through WRITE.
REQ-029 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; rsp_rdata=0 for stores.
REQ-030 SHALL drive mem_WE=0 and mem_WD=0 outside write cycles, and mem_Address=0 in IDLE and RESP.
REQ-031 SHALL meet these latencies, counted from the accept edge to rsp_valid high: load 2 cycles, word store 2, sub-word store 3, fault 1.
REQ-032 SHALL ignore req_valid while not in IDLE; back-to-back requests have at least one IDLE cycle between them.
REQ-033 SHALL hold rsp_rdata and rsp_fault stable until the next RESP.

Reset
REQ-034 SHALL, on reset low, immediately force state IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_WE=0, mem_WD=0, mem_Address=0.
REQ-035 SHALL, when reset is asserted mid-transaction (including during WRITE), abandon the transaction with no write and no response.

Verification
REQ-036 Word store/load: SW addr=0x8 data=0xDEADBEEF -> mem_WE pulse with mem_Address=2 after 1 cycle, rsp_valid after 2 cycles; LW 0x8 -> rsp_rdata=0xDEADBEEF.
REQ-037 Byte RMW: word 2=0xDEADBEEF, SB addr=0x9 data=0x12 -> word 2=0xDEAD12EF, rsp_valid after 3 cycles; LB 0x9 signed -> 0x00000012; LB 0xB signed -> 0xFFFFFFDE; LBU 0xB -> 0x000000DE.
REQ-038 Halfword: SH 0xA data=0xCAFE -> word 2=0xCAFE12EF; LH 0xA signed -> 0xFFFFCAFE; LHU 0xA -> 0x0000CAFE.
REQ-039 Faults: LW 0x6, LH 0x3, size=11, SW 0x190 (index 100) -> rsp_fault=1 after 1 cycle, rsp_rdata=0, mem_WE never asserted.
REQ-040 Reset mid-operation: SB accepted, reset low during WRITE -> mem_WE drops at once, no rsp_valid, target word unchanged, req_ready=1 after reset release.
